// File: rtl/r5_out_serializer_if.sv
// Handshake bundle for the radix-5 output serializer: one parallel frame in,
// one complex sample per beat out.
interface r5_out_serializer_if #(
  parameter int DW    = 32,
  parameter int NPT   = 5,
  parameter int IDX_W = 3
);
  logic              in_valid;
  logic              in_ready;
  logic [NPT*DW-1:0] in_re;
  logic [NPT*DW-1:0] in_img;
  logic              out_valid;
  logic              out_ready;
  logic [DW-1:0]     out_re;
  logic [DW-1:0]     out_img;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;

  modport slave (
    input  in_valid, in_re, in_img, out_ready,
    output in_ready, out_valid, out_re, out_img, out_idx, out_last
  );

  modport master (
    output in_valid, in_re, in_img, out_ready,
    input  in_ready, out_valid, out_re, out_img, out_idx, out_last
  );
endinterface

// File: rtl/r5_out_serializer.sv
// Captures one NPT-sample complex frame in a single handshake and replays it
// one sample per beat; the next frame may load on the last beat with no bubble.
module r5_out_serializer #(
  parameter int DW    = 32,
  parameter int NPT   = 5,
  parameter int IDX_W = 3,
  parameter int FCW   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  r5_out_serializer_if.slave    bus,
  output logic [FCW-1:0]        frame_cnt
);

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [IDX_W-1:0]  r_idx;
  logic [NPT*DW-1:0] r_bank_re;
  logic [NPT*DW-1:0] r_bank_img;
  logic [FCW-1:0]    r_frame_cnt;

  logic w_last;
  logic w_frame_done;
  logic w_in_ready;
  logic w_accept;

  assign w_last       = (r_state == SEND) && (r_idx == IDX_W'(NPT - 1));
  assign w_frame_done = w_last && bus.out_ready;
  // The bank may only reload in IDLE or on the beat that drains the last sample.
  assign w_in_ready   = rst_n && ((r_state == IDLE) || w_frame_done);
  assign w_accept     = w_in_ready && bus.in_valid;
  assign frame_cnt    = r_frame_cnt;

  // NOTE: non-blocking assignments in clocked blocks keep every register
  // sampling pre-edge values, independent of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // NOTE: the default assignment at the top of each always_comb guarantees
  // every path drives the signal, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next_state = SEND;
      SEND: if (w_frame_done) w_next_state = w_accept ? SEND : IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = w_in_ready;
    bus.out_valid = 1'b0;
    bus.out_re    = '0;
    bus.out_img   = '0;
    bus.out_idx   = '0;
    bus.out_last  = 1'b0;
    if (r_state == SEND) begin
      bus.out_valid = 1'b1;
      bus.out_re    = r_bank_re[int'(r_idx)*DW +: DW];
      bus.out_img   = r_bank_img[int'(r_idx)*DW +: DW];
      bus.out_idx   = r_idx;
      bus.out_last  = w_last;
    end
  end

  // NOTE: the sample bank is flop-based and small, so it is cleared on reset
  // to give deterministic contents; larger RAM-style storage would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_bank_re   <= '0;
      r_bank_img  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_bank_re  <= bus.in_re;
        r_bank_img <= bus.in_img;
        r_idx      <= '0;
      end else if ((r_state == SEND) && bus.out_ready && !w_last) begin
        r_idx <= r_idx + IDX_W'(1);
      end
      if (w_frame_done) begin
        r_frame_cnt <= r_frame_cnt + FCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_r5_out_serializer.sv
// Directed bench for r5_out_serializer: reset, single frame, stall, back-to-back,
// counter wrap and mid-frame asynchronous reset.
module tb_r5_out_serializer;
  localparam int DW    = 32;
  localparam int NPT   = 5;
  localparam int IDX_W = 3;
  localparam int FCW   = 16;
  localparam int BW    = 2 + IDX_W + 2*DW;

  typedef logic [DW-1:0] word_t;
  typedef word_t frame_t [NPT];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [FCW-1:0] frame_cnt;
  always #5 clk = ~clk;

  r5_out_serializer_if #(.DW(DW), .NPT(NPT), .IDX_W(IDX_W)) bus ();

  r5_out_serializer #(.DW(DW), .NPT(NPT), .IDX_W(IDX_W), .FCW(FCW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus.slave),
    .frame_cnt (frame_cnt)
  );

  int checks = 0;
  int errors = 0;
  logic [FCW-1:0] exp_fc = '0;

  frame_t frame_a = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h40A00000};

  function automatic frame_t make_frame(input word_t base);
    frame_t f;
    for (int k = 0; k < NPT; k++) f[k] = base + word_t'(k * 32'h0101);
    return f;
  endfunction

  function automatic logic [NPT*DW-1:0] pack(input frame_t f, input logic neg);
    logic [NPT*DW-1:0] p;
    for (int k = 0; k < NPT; k++) p[k*DW +: DW] = neg ? (f[k] | 32'h80000000) : f[k];
    return p;
  endfunction

  // {valid, last, idx, re, img}: the image of an active beat for sample k
  function automatic logic [BW-1:0] exp_beat(input frame_t f, input int k);
    return {1'b1, (k == NPT - 1), IDX_W'(k), f[k], f[k] | 32'h80000000};
  endfunction

  function automatic logic [BW-1:0] obs_beat();
    return {bus.out_valid, bus.out_last, bus.out_idx, bus.out_re, bus.out_img};
  endfunction

  task automatic load(input frame_t f);
    bus.in_re  = pack(f, 1'b0);
    bus.in_img = pack(f, 1'b1);
  endtask

  task automatic test_reset();
    logic [BW-1:0] got;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_re     = '0;
    bus.in_img    = '0;
    rst_n = 1'b0;
    #12;
    got = obs_beat();
    checks++;
    if (got !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h expected 0", got);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    checks++;
    if (frame_cnt !== '0) begin
      errors++; $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL release_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_single_frame();
    logic [BW-1:0] got;
    @(negedge clk);
    load(frame_a);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL single_accept_ready: got %b expected 1", bus.in_ready);
    end
    @(posedge clk);
    for (int k = 0; k < NPT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      got = obs_beat();
      checks++;
      if (got !== exp_beat(frame_a, k)) begin
        errors++; $display("FAIL single_beat%0d: got %h expected %h", k, got, exp_beat(frame_a, k));
      end
    end
    exp_fc++;
    @(negedge clk);
    #1;
    got = obs_beat();
    checks++;
    if ({got, bus.in_ready, frame_cnt} !== {{BW{1'b0}}, 1'b1, exp_fc}) begin
      errors++; $display("FAIL single_idle: beat %h ready %b cnt %h expected beat 0 ready 1 cnt %h",
                         got, bus.in_ready, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] got;
    logic [7:0] pat = 8'b1110_0011;  // bit c is out_ready in cycle c: stall at idx 2
    int exp_idx = 0;
    @(negedge clk);
    load(frame_a);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = pat[c];
      #1;
      got = obs_beat();
      checks++;
      if (got !== exp_beat(frame_a, exp_idx)) begin
        errors++; $display("FAIL stall_cycle%0d: got %h expected %h", c, got, exp_beat(frame_a, exp_idx));
      end
      if (!pat[c]) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++; $display("FAIL stall_in_ready%0d: got %b expected 0", c, bus.in_ready);
        end
      end
      @(posedge clk);
      if (pat[c]) exp_idx++;
    end
    exp_fc++;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.out_valid, frame_cnt} !== {1'b0, exp_fc}) begin
      errors++; $display("FAIL stall_done: valid %b cnt %h expected valid 0 cnt %h", bus.out_valid, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] got;
    logic [BW-1:0] want;
    frame_t f_c = make_frame(32'h11110000);
    frame_t f_d = make_frame(32'h22220000);
    @(negedge clk);
    load(f_c);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int c = 0; c < 2*NPT; c++) begin
      @(negedge clk);
      if (c == 0) load(f_d);
      if (c == NPT) bus.in_valid = 1'b0;
      #1;
      got  = obs_beat();
      want = (c < NPT) ? exp_beat(f_c, c) : exp_beat(f_d, c - NPT);
      checks++;
      if (got !== want) begin
        errors++; $display("FAIL b2b_beat%0d: got %h expected %h", c, got, want);
      end
      if (c == NPT - 1) begin
        checks++;
        if (bus.in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b_last_in_ready: got %b expected 1", bus.in_ready);
        end
      end
      @(posedge clk);
    end
    exp_fc += 2;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.out_valid, frame_cnt} !== {1'b0, exp_fc}) begin
      errors++; $display("FAIL b2b_done: valid %b cnt %h expected valid 0 cnt %h", bus.out_valid, frame_cnt, exp_fc);
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_frame_cnt = 16'hFFFF;
    #1;
    release dut.r_frame_cnt;
    #1;
    checks++;
    if (frame_cnt !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt);
    end
    @(negedge clk);
    load(frame_a);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NPT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    exp_fc = '0;
    @(negedge clk);
    #1;
    checks++;
    if (frame_cnt !== 16'h0000) begin
      errors++; $display("FAIL wrap_result: got %h expected 0000", frame_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic [BW-1:0] got;
    frame_t f_b = make_frame(32'h3C000000);
    @(negedge clk);
    load(frame_a);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
    end
    #1;
    got = obs_beat();
    checks++;
    if (got !== exp_beat(frame_a, 3)) begin
      errors++; $display("FAIL areset_pre_beat3: got %h expected %h", got, exp_beat(frame_a, 3));
    end
    #2;
    rst_n = 1'b0;
    #1;
    got = obs_beat();
    checks++;
    if ({got, bus.in_ready, frame_cnt} !== {{BW{1'b0}}, 1'b0, exp_fc}) begin
      errors++; $display("FAIL areset_now: beat %h ready %b cnt %h expected beat 0 ready 0 cnt %h",
                         got, bus.in_ready, frame_cnt, exp_fc);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load(f_b);
    bus.in_valid = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NPT; k++) begin
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      got = obs_beat();
      checks++;
      if (got !== exp_beat(f_b, k)) begin
        errors++; $display("FAIL areset_after_beat%0d: got %h expected %h", k, got, exp_beat(f_b, k));
      end
    end
    exp_fc++;
    @(negedge clk);
    #1;
    checks++;
    if (frame_cnt !== exp_fc) begin
      errors++; $display("FAIL areset_after_cnt: got %h expected %h", frame_cnt, exp_fc);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
